shared_wb_arbiter: RTL and testbench
====================================

SHARED_WB_ARBITER -- requirements
Module: shared_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 4, giving the number of core shared-bus masters (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum stalled cycles before forced termination (range 1..65535).
REQ-003 The block SHALL have these ports:
- wb_clk_i  in  1  sole clock; all state on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- m_cyc_i  in  NUM_MASTERS  per-master cycle request.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_sel_i  in  4*NUM_MASTERS  per-master byte selects, master k at [4k+3:4k].
- m_adr_i  in  32*NUM_MASTERS  per-master address, master k at [32k+31:32k].
- m_dat_i  in  32*NUM_MASTERS  per-master write data, same packing.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_err_o  out  NUM_MASTERS  per-master timeout error flag.
- m_dat_o  out  32  read data, broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  shared-slave cycle, strobe, write enable.
- s_sel_o  out  4  shared-slave byte selects.
- s_adr_o, s_dat_o  out  32 each  shared-slave address and write data.
- s_ack_i  in  1  shared-slave acknowledge.
- s_dat_i  in  32  shared-slave read data.
- grant_o  out  NUM_MASTERS  one-hot current owner; zero when idle.

Function
REQ-004 The FSM SHALL have states IDLE, BUSY and ABORT.
REQ-005 In IDLE, when any m_cyc_i bit is high, the block SHALL register a winner and enter BUSY on the next edge, giving one cycle of arbitration latency.
REQ-006 Winner selection SHALL be round-robin: search from (last_grant+1) mod NUM_MASTERS upward with wrap-around; last_grant updates only on grant.
REQ-007 In BUSY, s_* outputs SHALL mirror the granted master's cyc/stb/we/sel/adr/dat combinationally; in IDLE and ABORT, s_cyc_o and s_stb_o SHALL be 0.
REQ-008 m_ack_o[g] SHALL equal s_ack_i & s_stb_o for the granted master g only; all other masters' ack and err SHALL be 0.
REQ-009 m_dat_o SHALL equal s_dat_i in BUSY.
REQ-010 In BUSY, when the granted master's m_cyc_i drops, the block SHALL return to IDLE on that edge; new requests are arbitrated from IDLE (one bubble cycle).
REQ-011 Lock: the grant SHALL NOT change while the owner holds m_cyc_i, regardless of other requests.
REQ-012 A master dropping m_cyc_i while not granted SHALL be silently withdrawn with no effect on state.

Reset
REQ-013 While wb_rst_i is high, the block SHALL force state IDLE, last_grant = NUM_MASTERS-1 (so master 0 wins first), timeout counter 0 and all outputs 0.
REQ-014 A reset asserted mid-transaction SHALL abandon it without issuing ack or err.

Configuration
REQ-015 With macro SHARED_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on grant and on each ack, and increment each BUSY cycle with s_stb_o=1 and s_ack_i=0.
REQ-016 With SHARED_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL enter ABORT.
REQ-017 In ABORT, the block SHALL pulse m_ack_o[g] and m_err_o[g] for exactly one cycle with m_dat_o = 32'hDEAD_BEEF, then return to IDLE.
REQ-018 A late s_ack_i arriving in ABORT or IDLE SHALL be ignored.
REQ-019 Without SHARED_ARB_TIMEOUT_EN, the counter and ABORT state SHALL be absent, m_err_o SHALL be tied 0, and a stalled slave SHALL hold the grant indefinitely.

Structure
REQ-020 State encodings, the 32'hDEAD_BEEF abort constant and counter width SHALL live in shared package softshell_pkg.
REQ-021 Round-robin selection SHALL be a sub-module rr_pick, purely combinational: request vector plus last index in, one-hot and index out.

Verification
REQ-022 Single master: master 1 reads, slave acks after 2 cycles with 32'h1234_5678 -> grant_o=4'b0010 one cycle after cyc, m_ack_o[1] pulses once, m_dat_o=32'h1234_5678.
REQ-023 Fairness: all 4 masters hold cyc continuously, each transaction a 1-cycle ack -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-024 Lock: master 0 issues back-to-back stb without dropping cyc while master 2 requests -> master 2 is not granted until master 0 drops cyc.
REQ-025 Timeout (macro on, TIMEOUT_CYCLES=4): slave never acks -> m_ack_o and m_err_o pulse together 4 cycles after stb with m_dat_o=32'hDEAD_BEEF; a later s_ack_i is ignored.
REQ-026 Reset mid-BUSY: wb_rst_i asserted for 1 cycle during a stalled write -> next cycle grant_o=0, s_cyc_o=0, no ack, and master 0 wins the next arbitration.

Source files
------------

// File: rtl/softshell_pkg.sv
// Shared definitions for the shared-slave Wishbone arbiter: FSM states,
// the timeout abort data word and the stall counter width.
package softshell_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_t;

   localparam logic [31:0] ABORT_DAT = 32'hDEAD_BEEF;
   localparam int          TMO_W     = 16;

endpackage

// File: rtl/shared_wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester above i_last
// wins, wrapping to the lowest index; no latency, no flow control.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic w_found;

   always_comb begin
      w_found = 1'b0;
      o_gnt   = '0;
      o_idx   = '0;
      // first pass covers indices above the last owner, second pass wraps
      for (int i = 0; i < N; i++) begin
         if (!w_found && i_req[i] && (i > int'(i_last))) begin
            w_found  = 1'b1;
            o_gnt[i] = 1'b1;
            o_idx    = i[IW-1:0];
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!w_found && i_req[i]) begin
            w_found  = 1'b1;
            o_gnt[i] = 1'b1;
            o_idx    = i[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/shared_wb_arbiter.sv
// Round-robin arbiter giving N Wishbone masters a locked path to one slave; one cycle
// arbitration latency, owner held while its cyc is high. SHARED_ARB_TIMEOUT_EN adds stall abort.
module shared_wb_arbiter
   import softshell_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [NUM_MASTERS-1:0]    m_cyc_i,
   input  logic [NUM_MASTERS-1:0]    m_stb_i,
   input  logic [NUM_MASTERS-1:0]    m_we_i,
   input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
   input  logic [32*NUM_MASTERS-1:0] m_adr_i,
   input  logic [32*NUM_MASTERS-1:0] m_dat_i,
   output logic [NUM_MASTERS-1:0]    m_ack_o,
   output logic [NUM_MASTERS-1:0]    m_err_o,
   output logic [31:0]               m_dat_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   output logic                      s_we_o,
   output logic [3:0]                s_sel_o,
   output logic [31:0]               s_adr_o,
   output logic [31:0]               s_dat_o,
   input  logic                      s_ack_i,
   input  logic [31:0]               s_dat_i,
   output logic [NUM_MASTERS-1:0]    grant_o
);

   localparam int IW = $clog2(NUM_MASTERS);

   arb_state_t             r_state, w_next;
   logic [NUM_MASTERS-1:0] r_grant, w_pick_oh;
   logic [IW-1:0]          r_last, w_pick_idx;
   logic                   w_busy, w_abort, w_take, w_tmo;
   logic                   w_own_cyc, w_own_stb, w_own_we;
   logic [3:0]             w_own_sel;
   logic [31:0]            w_own_adr, w_own_dat;

   rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
      .i_req  (m_cyc_i),
      .i_last (r_last),
      .o_gnt  (w_pick_oh),
      .o_idx  (w_pick_idx)
   );

   // outputs are gated by reset so an abandoned transfer never sees ack or err
   assign w_busy = (r_state == ST_BUSY) && !wb_rst_i;
   assign w_take = (r_state == ST_IDLE) && (|m_cyc_i);

   always_comb begin
      w_own_cyc = 1'b0;
      w_own_stb = 1'b0;
      w_own_we  = 1'b0;
      w_own_sel = '0;
      w_own_adr = '0;
      w_own_dat = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (r_grant[k]) begin
            w_own_cyc = m_cyc_i[k];
            w_own_stb = m_stb_i[k];
            w_own_we  = m_we_i[k];
            w_own_sel = m_sel_i[4*k +: 4];
            w_own_adr = m_adr_i[32*k +: 32];
            w_own_dat = m_dat_i[32*k +: 32];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (|m_cyc_i) w_next = ST_BUSY;
         ST_BUSY: begin
            if (!w_own_cyc)  w_next = ST_IDLE;
            else if (w_tmo)  w_next = ST_ABORT;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_last  <= IW'(NUM_MASTERS - 1);
         r_grant <= '0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_grant <= w_pick_oh;
            r_last  <= w_pick_idx;
         end
      end
   end

`ifdef SHARED_ARB_TIMEOUT_EN
   localparam logic [TMO_W-1:0] C_TMO = TMO_W'(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] r_cnt, w_cnt_inc;

   assign w_cnt_inc = r_cnt + TMO_W'(1);
   assign w_tmo     = s_stb_o && !s_ack_i && (w_cnt_inc == C_TMO);
   assign w_abort   = (r_state == ST_ABORT) && !wb_rst_i;
   assign m_err_o   = w_abort ? r_grant : '0;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)                        r_cnt <= '0;
      else if (w_take || (s_stb_o && s_ack_i)) r_cnt <= '0;
      else if (s_stb_o)                    r_cnt <= w_cnt_inc;
   end
`else
   logic w_unused_tmo;

   assign w_tmo        = 1'b0;
   assign w_abort      = 1'b0;
   assign m_err_o      = '0;
   assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

   assign s_cyc_o = w_busy & w_own_cyc;
   assign s_stb_o = w_busy & w_own_stb;
   assign s_we_o  = w_busy & w_own_we;
   assign s_sel_o = w_busy ? w_own_sel : 4'd0;
   assign s_adr_o = w_busy ? w_own_adr : 32'd0;
   assign s_dat_o = w_busy ? w_own_dat : 32'd0;

   assign grant_o = (w_busy || w_abort) ? r_grant : '0;
   assign m_ack_o = w_abort ? r_grant : (r_grant & {NUM_MASTERS{s_ack_i & s_stb_o}});
   assign m_dat_o = w_busy ? s_dat_i : (w_abort ? ABORT_DAT : 32'd0);

endmodule

// File: tb/tb_shared_wb_arbiter.sv
// Directed bench for shared_wb_arbiter with 4 masters and TIMEOUT_CYCLES=4.
module tb_shared_wb_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   m_cyc, m_stb, m_we;
   logic [15:0]  m_sel;
   logic [127:0] m_adr, m_dat;
   logic [3:0]   m_ack, m_err, grant;
   logic [31:0]  m_dat_o;
   logic         s_cyc, s_stb, s_we, s_ack;
   logic [3:0]   s_sel;
   logic [31:0]  s_adr, s_dat_o, s_dat;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shared_wb_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(4)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .m_cyc_i  (m_cyc),
      .m_stb_i  (m_stb),
      .m_we_i   (m_we),
      .m_sel_i  (m_sel),
      .m_adr_i  (m_adr),
      .m_dat_i  (m_dat),
      .m_ack_o  (m_ack),
      .m_err_o  (m_err),
      .m_dat_o  (m_dat_o),
      .s_cyc_o  (s_cyc),
      .s_stb_o  (s_stb),
      .s_we_o   (s_we),
      .s_sel_o  (s_sel),
      .s_adr_o  (s_adr),
      .s_dat_o  (s_dat_o),
      .s_ack_i  (s_ack),
      .s_dat_i  (s_dat),
      .grant_o  (grant)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
      m_adr = '0; m_dat = '0; s_ack = 1'b0; s_dat = '0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      m_cyc = 4'b1111; m_stb = 4'b1111; m_we = 4'b1111; m_sel = 16'hFFFF;
      m_adr = {4{32'hAAAA_5555}}; m_dat = {4{32'h5A5A_A5A5}};
      s_ack = 1'b1; s_dat = 32'hFFFF_FFFF;
      tick(); tick();
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      total++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin bad++; $display("FAIL reset_s_ctl got=%b exp=000", {s_cyc, s_stb, s_we}); end
      total++; if ({s_sel, s_adr, s_dat_o} !== 68'd0) begin bad++; $display("FAIL reset_s_bus got=%h exp=0", {s_sel, s_adr, s_dat_o}); end
      total++; if ({m_ack, m_err} !== 8'd0) begin bad++; $display("FAIL reset_ack_err got=%b exp=0", {m_ack, m_err}); end
      total++; if (m_dat_o !== 32'd0) begin bad++; $display("FAIL reset_m_dat got=%h exp=0", m_dat_o); end
      do_reset();
   endtask

   task automatic test_single;
      do_reset();
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_sel[7:4] = 4'b1111;
      m_adr[63:32] = 32'h0000_0100;
      #1;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_arb_latency got=%b exp=0000", grant); end
      tick();
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b exp=0010", grant); end
      total++; if ({s_cyc, s_stb, s_we, s_sel} !== 7'b110_1111) begin bad++; $display("FAIL single_s_ctl got=%b exp=1101111", {s_cyc, s_stb, s_we, s_sel}); end
      total++; if (s_adr !== 32'h0000_0100) begin bad++; $display("FAIL single_s_adr got=%h exp=00000100", s_adr); end
      total++; if (m_ack !== 4'b0000) begin bad++; $display("FAIL single_no_early_ack got=%b exp=0000", m_ack); end
      tick();
      total++; if (m_ack !== 4'b0000) begin bad++; $display("FAIL single_wait_ack got=%b exp=0000", m_ack); end
      tick();
      s_ack = 1'b1; s_dat = 32'h1234_5678;
      #1;
      total++; if (m_ack !== 4'b0010) begin bad++; $display("FAIL single_ack got=%b exp=0010", m_ack); end
      total++; if (m_dat_o !== 32'h1234_5678) begin bad++; $display("FAIL single_rdata got=%h exp=12345678", m_dat_o); end
      tick();
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      #1;
      total++; if (m_ack !== 4'b0000) begin bad++; $display("FAIL single_ack_once got=%b exp=0000", m_ack); end
      tick();
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_release got=%b exp=0000", grant); end
   endtask

   task automatic test_fairness;
      logic [3:0] exp_g;
      int e;
      do_reset();
      m_cyc = 4'b1111; m_stb = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         e = n % 4;
         exp_g = 4'b0001 << e;
         tick();
         total++; if (grant !== exp_g) begin bad++; $display("FAIL fair_grant_%0d got=%b exp=%b", n, grant, exp_g); end
         s_ack = 1'b1;
         #1;
         total++; if (m_ack !== exp_g) begin bad++; $display("FAIL fair_ack_%0d got=%b exp=%b", n, m_ack, exp_g); end
         tick();
         s_ack = 1'b0; m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
         #1;
         total++; if (m_ack !== 4'b0000) begin bad++; $display("FAIL fair_ack_drop_%0d got=%b exp=0000", n, m_ack); end
         tick();
         total++; if (grant !== 4'b0000) begin bad++; $display("FAIL fair_idle_%0d got=%b exp=0000", n, grant); end
         if (n < 4) begin
            m_cyc[e] = 1'b1; m_stb[e] = 1'b1;
         end else begin
            m_cyc = '0; m_stb = '0;
         end
      end
      tick();
   endtask

   task automatic test_lock;
      do_reset();
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      tick();
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL lock_first got=%b exp=0001", grant); end
      m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_cyc[1] = 1'b1;
      for (int b = 0; b < 3; b++) begin
         s_ack = 1'b1;
         #1;
         total++; if (m_ack !== 4'b0001) begin bad++; $display("FAIL lock_ack_%0d got=%b exp=0001", b, m_ack); end
         tick();
         if (b == 0) m_cyc[1] = 1'b0;
         total++; if (grant !== 4'b0001) begin bad++; $display("FAIL lock_hold_%0d got=%b exp=0001", b, grant); end
      end
      s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      tick();
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL lock_bubble got=%b exp=0000", grant); end
      tick();
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL lock_next_owner got=%b exp=0100", grant); end
      m_cyc = '0; m_stb = '0;
      tick(); tick();
   endtask

`ifdef SHARED_ARB_TIMEOUT_EN
   task automatic test_timeout;
      do_reset();
      m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_we[3] = 1'b1;
      tick();
      total++; if (grant !== 4'b1000) begin bad++; $display("FAIL tmo_grant got=%b exp=1000", grant); end
      for (int c = 1; c < 4; c++) begin
         tick();
         total++; if ({m_ack, m_err} !== 8'd0) begin bad++; $display("FAIL tmo_stall_%0d got=%b exp=0", c, {m_ack, m_err}); end
      end
      tick();
      total++; if (m_ack !== 4'b1000) begin bad++; $display("FAIL tmo_ack got=%b exp=1000", m_ack); end
      total++; if (m_err !== 4'b1000) begin bad++; $display("FAIL tmo_err got=%b exp=1000", m_err); end
      total++; if (m_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tmo_data got=%h exp=deadbeef", m_dat_o); end
      total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL tmo_s_cyc got=%b exp=0", s_cyc); end
      m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b1;
      tick();
      total++; if ({m_ack, m_err} !== 8'd0) begin bad++; $display("FAIL tmo_late_ack got=%b exp=0", {m_ack, m_err}); end
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL tmo_idle got=%b exp=0000", grant); end
      s_ack = 1'b0;
   endtask
`else
   task automatic test_timeout;
      do_reset();
      m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_we[3] = 1'b1;
      tick();
      repeat (10) tick();
      total++; if (grant !== 4'b1000) begin bad++; $display("FAIL stall_hold got=%b exp=1000", grant); end
      total++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin bad++; $display("FAIL stall_s_ctl got=%b exp=111", {s_cyc, s_stb, s_we}); end
      total++; if ({m_ack, m_err} !== 8'd0) begin bad++; $display("FAIL stall_no_err got=%b exp=0", {m_ack, m_err}); end
      s_ack = 1'b1;
      #1;
      total++; if (m_ack !== 4'b1000) begin bad++; $display("FAIL stall_final_ack got=%b exp=1000", m_ack); end
      tick();
      s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
      tick();
   endtask
`endif

   task automatic test_reset_mid;
      do_reset();
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
      m_dat[63:32] = 32'hCAFE_0001;
      tick();
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL rmid_grant got=%b exp=0010", grant); end
      total++; if (s_dat_o !== 32'hCAFE_0001) begin bad++; $display("FAIL rmid_wdata got=%h exp=cafe0001", s_dat_o); end
      tick();
      rst = 1'b1; s_ack = 1'b1;
      #1;
      total++; if ({m_ack, m_err} !== 8'd0) begin bad++; $display("FAIL rmid_no_ack got=%b exp=0", {m_ack, m_err}); end
      tick();
      rst = 1'b0; s_ack = 1'b0;
      #1;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rmid_grant_clear got=%b exp=0000", grant); end
      total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL rmid_s_cyc got=%b exp=0", s_cyc); end
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      tick();
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_master0_wins got=%b exp=0001", grant); end
      m_cyc = '0; m_stb = '0; m_we = '0;
      tick(); tick();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_fairness();
      test_lock();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
